// File: rtl/ysyx_23060236_axi_rd_master.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_axi_rd_master
// Brief    : AXI4-Lite single-beat read initiator with error reporting and an
//            R-phase watchdog that drains late beats after a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060236_axi_rd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_ar    = 3'd1;
  localparam logic [2:0] c_st_r     = 3'd2;
  localparam logic [2:0] c_st_rsp   = 3'd3;
  localparam logic [2:0] c_st_drain = 3'd4;

  localparam logic             c_wdog_en  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [31:0]      r_araddr;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;
  logic             r_rsp_timeout;
  logic             w_timeout;

  // A beat arriving in the expiry cycle takes priority over the watchdog.
  assign w_timeout = c_wdog_en && (r_cnt == c_cnt_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (req_valid) w_state_nxt = c_st_ar;
      c_st_ar:    if (arready)   w_state_nxt = c_st_r;
      c_st_r:     if (rvalid || w_timeout) w_state_nxt = c_st_rsp;
      c_st_rsp:   if (rsp_ready) w_state_nxt = r_rsp_timeout ? c_st_drain : c_st_idle;
      c_st_drain: if (rvalid)    w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      c_st_idle:  req_ready = 1'b1;
      c_st_ar:    arvalid   = 1'b1;
      c_st_r:     rready    = 1'b1;
      c_st_rsp:   rsp_valid = 1'b1;
      c_st_drain: rready    = 1'b1;
      default:    req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_araddr      <= 32'h0;
      r_cnt         <= '0;
      r_rsp_data    <= 32'h0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == c_st_idle && req_valid) begin
        r_araddr <= req_addr;
      end
      if (r_state == c_st_ar && arready) begin
        r_cnt <= '0;
      end
      if (r_state == c_st_r) begin
        if (rvalid) begin
          r_rsp_data    <= rdata;
          r_rsp_err     <= (rresp != 2'b00);
          r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_data    <= 32'h0;
          r_rsp_err     <= 1'b1;
          r_rsp_timeout <= 1'b1;
        end else if (c_wdog_en && r_cnt != c_cnt_max) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign araddr      = r_araddr;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_axi_rd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060236_axi_rd_master
// Brief    : Self-checking bench with a configurable AXI responder and a
//            response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060236_axi_rd_master;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // responder configuration
  int          cfg_ar_delay = 0;
  int          cfg_r_delay  = 0;
  logic [31:0] cfg_rdata    = 32'h0;
  logic [1:0]  cfg_rresp    = 2'b00;
  logic        cfg_silent   = 1'b0;
  logic        late_go      = 1'b0;

  ysyx_23060236_axi_rd_master #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clock = ~clock;

  // Responder: acts on negedges; values seen at the previous negedge equal
  // those present at the intervening posedge, so handshakes are inferred here.
  logic arvalid_q = 1'b0, rready_q = 1'b0, r_arm = 1'b0;
  int   ar_wait = 0, r_wait = 0;
  always @(negedge clock) begin
    if (!reset) begin
      arready = 1'b0; rvalid = 1'b0; r_arm = 1'b0; ar_wait = 0; r_wait = 0;
      arvalid_q = 1'b0; rready_q = 1'b0;
    end else begin
      if (arvalid_q && arready) begin arready = 1'b0; r_arm = 1'b1; r_wait = 0; end
      if (rvalid && rready_q) rvalid = 1'b0;
      if (arvalid && !arready) begin
        if (ar_wait == cfg_ar_delay) begin arready = 1'b1; ar_wait = 0; end
        else ar_wait++;
      end
      if (r_arm && !cfg_silent) begin
        if (r_wait == cfg_r_delay) begin
          rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp; r_arm = 1'b0;
          sb.push_back('{data: cfg_rdata, err: (cfg_rresp != 2'b00), to: 1'b0});
        end else r_wait++;
      end
      if (late_go && !rvalid) begin
        rvalid = 1'b1; rdata = 32'hAAAA_AAAA; rresp = 2'b00; late_go = 1'b0;
      end
      arvalid_q = arvalid;
      rready_q  = rready;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({req_ready, arvalid, rready, rsp_valid, rsp_err, rsp_timeout} !== 6'b100000 ||
        rsp_data !== 32'h0 || araddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rr=%b av=%b rd=%b rv=%b err=%b to=%b data=%h addr=%h, want 1 0 0 0 0 0 0 0",
               req_ready, arvalid, rready, rsp_valid, rsp_err, rsp_timeout, rsp_data, araddr);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    exp_t e;
    cfg_ar_delay = 0; cfg_r_delay = 0; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    req_valid = 1'b1; req_addr = 32'h0200_BFF8;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL zw_req_ready: got %b want 1", req_ready); end
    tick(); req_valid = 1'b0;
    n_checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0200_BFF8) begin
      n_fail++; $display("FAIL zw_ar: got arvalid=%b araddr=%h want 1 0200bff8", arvalid, araddr);
    end
    tick();
    n_checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      n_fail++; $display("FAIL zw_r: got rready=%b arvalid=%b want 1 0", rready, arvalid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL zw_rsp_latency: got rsp_valid=%b sb=%0d want 1 1", rsp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({rsp_data, rsp_err, rsp_timeout} !== {e.data, e.err, e.to}) begin
        n_fail++; $display("FAIL zw_rsp: got %h/%b/%b want %h/%b/%b", rsp_data, rsp_err, rsp_timeout, e.data, e.err, e.to);
      end
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL zw_idle: got rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_delayed();
    exp_t e;
    int ar_cyc = 0, r_cyc = 0;
    logic bad_addr = 1'b0, bad_rr = 1'b0, seen = 1'b0;
    cfg_ar_delay = 3; cfg_r_delay = 5; cfg_rdata = 32'h0BAD_F00D; cfg_rresp = 2'b00;
    req_valid = 1'b1; req_addr = 32'h1000_0040;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        if (arvalid) begin ar_cyc++; if (araddr !== 32'h1000_0040) bad_addr = 1'b1; end
        if (rready) r_cyc++;
        if (req_ready !== 1'b0) bad_rr = 1'b1;
        tick();
      end
    end
    n_checks++;
    if (!seen || ar_cyc != 4 || r_cyc != 6) begin
      n_fail++; $display("FAIL dly_timing: got seen=%b ar_cycles=%0d r_cycles=%0d want 1 4 6", seen, ar_cyc, r_cyc);
    end
    n_checks++;
    if (bad_addr || bad_rr) begin
      n_fail++; $display("FAIL dly_stable: got addr_glitch=%b req_ready_glitch=%b want 0 0", bad_addr, bad_rr);
    end
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({rsp_data, rsp_err, rsp_timeout} !== {e.data, e.err, e.to}) begin
        n_fail++; $display("FAIL dly_rsp: got %h/%b/%b want %h/%b/%b", rsp_data, rsp_err, rsp_timeout, e.data, e.err, e.to);
      end
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL dly_idle: got req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_error();
    logic [1:0]  resps [2] = '{2'b10, 2'b01};
    logic [31:0] datas [2] = '{32'hDEAD_BEEF, 32'h0123_4567};
    exp_t e;
    logic seen;
    cfg_ar_delay = 0; cfg_r_delay = 0;
    for (int k = 0; k < 2; k++) begin
      cfg_rdata = datas[k]; cfg_rresp = resps[k]; seen = 1'b0;
      req_valid = 1'b1; req_addr = 32'h2000_0000 + 32'(k * 4);
      tick(); req_valid = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (rsp_valid) seen = 1'b1; else tick();
      end
      n_checks++;
      if (!seen || sb.size() == 0) begin
        n_fail++; $display("FAIL err%0d_rsp_seen: got rsp_valid=%b sb=%0d want 1 1", k, seen, sb.size());
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({rsp_data, rsp_err, rsp_timeout} !== {e.data, 1'b1, 1'b0} || e.err !== 1'b1) begin
          n_fail++; $display("FAIL err%0d_rsp: got %h/%b/%b want %h/1/0", k, rsp_data, rsp_err, rsp_timeout, e.data);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic seen = 1'b0, bad = 1'b0;
    cfg_ar_delay = 0; cfg_r_delay = 0; cfg_rdata = 32'hCAFE_0001; cfg_rresp = 2'b00;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h3000_0000;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1; else tick();
    end
    n_checks++;
    if (!seen || sb.size() == 0) begin
      n_fail++; $display("FAIL b2b_first_seen: got rsp_valid=%b sb=%0d want 1 1", seen, sb.size());
      e = '{data: 32'hCAFE_0001, err: 1'b0, to: 1'b0};
    end else e = sb.pop_front();
    req_valid = 1'b1; req_addr = 32'h3000_0100;
    for (int h = 0; h < 5; h++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err || req_ready !== 1'b0) bad = 1'b1;
      if (h == 4) rsp_ready = 1'b1;
      tick();
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL b2b_hold: got unstable response or req_ready during hold, last rsp_valid=%b data=%h want 1 %h", rsp_valid, rsp_data, e.data);
    end
    cfg_rdata = 32'hCAFE_0002;
    n_checks++;
    if (req_ready !== 1'b1 || arvalid !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_gap: got req_ready=%b arvalid=%b rsp_valid=%b want 1 0 0", req_ready, arvalid, rsp_valid);
    end
    tick(); req_valid = 1'b0;
    n_checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h3000_0100) begin
      n_fail++; $display("FAIL b2b_second_ar: got arvalid=%b araddr=%h want 1 30000100", arvalid, araddr);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1; else tick();
    end
    if (seen && sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({rsp_data, rsp_err, rsp_timeout} !== {e.data, e.err, e.to}) begin
        n_fail++; $display("FAIL b2b_second_rsp: got %h/%b/%b want %h/%b/%b", rsp_data, rsp_err, rsp_timeout, e.data, e.err, e.to);
      end
    end else begin
      n_checks++; n_fail++; $display("FAIL b2b_second_seen: got rsp_valid=0 want 1");
    end
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    int r_cyc = 0;
    logic seen = 1'b0, leaked = 1'b0, back = 1'b0;
    cfg_ar_delay = 0; cfg_silent = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0200_4000;
    sb.push_back('{data: 32'h0, err: 1'b1, to: 1'b1});
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin if (rready) r_cyc++; tick(); end
    end
    n_checks++;
    if (!seen || r_cyc != 16) begin
      n_fail++; $display("FAIL to_latency: got seen=%b r_cycles=%0d want 1 16", seen, r_cyc);
    end
    e = sb.pop_front();
    n_checks++;
    if ({rsp_data, rsp_err, rsp_timeout} !== {e.data, e.err, e.to}) begin
      n_fail++; $display("FAIL to_rsp: got %h/%b/%b want %h/%b/%b", rsp_data, rsp_err, rsp_timeout, e.data, e.err, e.to);
    end
    for (int d = 0; d < 3; d++) begin
      tick();
      n_checks++;
      if (rready !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL to_drain%0d: got rready=%b req_ready=%b rsp_valid=%b want 1 0 0", d, rready, req_ready, rsp_valid);
      end
    end
    late_go = 1'b1;
    for (int i = 0; i < 10 && !back; i++) begin
      tick();
      if (rsp_valid) leaked = 1'b1;
      if (req_ready) back = 1'b1;
    end
    n_checks++;
    if (!back || leaked || rvalid !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL to_late_beat: got idle=%b reported=%b rvalid=%b sb=%0d want 1 0 0 0", back, leaked, rvalid, sb.size());
    end
    cfg_silent = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic seen = 1'b0;
    cfg_ar_delay = 0; cfg_r_delay = 10; cfg_rdata = 32'h1111_1111; cfg_rresp = 2'b00;
    req_valid = 1'b1; req_addr = 32'h4000_0000;
    tick(); req_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (rready !== 1'b1) begin n_fail++; $display("FAIL rst_precond: got rready=%b want 1", rready); end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({arvalid, rready, rsp_valid, req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_async: got arvalid=%b rready=%b rsp_valid=%b req_ready=%b want 0 0 0 1",
                         arvalid, rready, rsp_valid, req_ready);
    end
    tick(); reset = 1'b1;
    tick();
    cfg_r_delay = 0; cfg_rdata = 32'h55AA_33CC; cfg_rresp = 2'b00;
    req_valid = 1'b1; req_addr = 32'h4000_0010;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1; else tick();
    end
    if (seen && sb.size() == 1) begin
      e = sb.pop_front();
      n_checks++;
      if ({rsp_data, rsp_err, rsp_timeout, araddr} !== {e.data, e.err, e.to, 32'h4000_0010}) begin
        n_fail++; $display("FAIL rst_recover: got %h/%b/%b addr=%h want %h/%b/%b addr=40000010",
                           rsp_data, rsp_err, rsp_timeout, araddr, e.data, e.err, e.to);
      end
    end else begin
      n_checks++; n_fail++; $display("FAIL rst_recover_seen: got rsp_valid=%b sb=%0d want 1 1", seen, sb.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed();
    test_error();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
